// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Holds the receive FSM encoding, the prefix bytes and the parameter defaults.
package ps2_keyboard_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int FILTER_DEF  = 8;
  localparam int TIMEOUT_DEF = 50000;

  // True when data plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_clk_filter.sv
// Synchronizes ps2_clk/ps2_data, deglitches the clock, emits a falling-edge tick.
// Tick lags the raw edge by 2 sync + FILTER + 1 cycles; no backpressure.
module ps2_clk_filter
  import ps2_keyboard_rx_pkg::*;
#(
  parameter int FILTER = FILTER_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_fall_tick,
  output logic o_data_sync
);

  localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_data_sync;
  logic          r_filt;
  logic [CW-1:0] r_cnt;
  logic          r_fall;
  logic          w_diff;
  logic          w_flip;

  assign w_diff = r_clk_sync[1] ^ r_filt;
  // Flip on the FILTER-th consecutive cycle of disagreement.
  assign w_flip = w_diff && (r_cnt == CW'(FILTER - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_filt      <= 1'b1;
      r_cnt       <= '0;
      r_fall      <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
      r_data_sync <= {r_data_sync[0], i_ps2_data};
      r_fall      <= w_flip && r_filt;
      if (!w_diff || w_flip) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_flip) begin
        r_filt <= ~r_filt;
      end
    end
  end

  assign o_fall_tick = r_fall;
  assign o_data_sync = r_data_sync[1];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frames bytes, decodes E0/F0 prefixes, holds current make code.
// Outputs update 1 clk after the stop-bit falling tick; no backpressure (pulse outputs).
module ps2_keyboard_rx
  import ps2_keyboard_rx_pkg::*;
#(
  parameter int FILTER  = FILTER_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_ps2,
  output logic       o_extended,
  output logic       o_code_valid,
  output logic       o_frame_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  rx_state_t     r_state;
  rx_state_t     w_state_nxt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par_err;
  logic [TW-1:0] r_idle_cnt;
  logic          r_ext_flag;
  logic          r_brk_flag;
  logic [7:0]    r_ps2;
  logic          r_extended;
  logic          r_code_valid;
  logic          r_frame_err;
  logic          w_fall_tick;
  logic          w_data;
  logic          w_timeout;
  logic          w_byte_ok;
  logic          w_frame_err;

  ps2_clk_filter #(
    .FILTER (FILTER)
  ) u_clk_filter (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_ps2_clk   (i_ps2_clk),
    .i_ps2_data  (i_ps2_data),
    .o_fall_tick (w_fall_tick),
    .o_data_sync (w_data)
  );

  // Abort on the cycle the idle count would reach TIMEOUT.
  assign w_timeout = (r_state != IDLE) && !w_fall_tick &&
                     (r_idle_cnt >= TW'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_byte_ok   = 1'b0;
    w_frame_err = 1'b0;
    if (w_timeout) begin
      w_state_nxt = IDLE;
      w_frame_err = 1'b1;
    end else if (w_fall_tick) begin
      case (r_state)
        IDLE: begin
          if (w_data) w_frame_err = 1'b1;
          else        w_state_nxt = DATA;
        end
        DATA: begin
          if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
        end
        PARITY: w_state_nxt = STOP;
        STOP: begin
          w_state_nxt = IDLE;
          if (w_data && !r_par_err) w_byte_ok   = 1'b1;
          else                      w_frame_err = 1'b1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_err    <= 1'b0;
      r_idle_cnt   <= '0;
      r_ext_flag   <= 1'b0;
      r_brk_flag   <= 1'b0;
      r_ps2        <= 8'h00;
      r_extended   <= 1'b0;
      r_code_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_code_valid <= 1'b0;
      r_frame_err  <= w_frame_err;

      if (w_fall_tick || r_state == IDLE || w_timeout) r_idle_cnt <= '0;
      else                                             r_idle_cnt <= r_idle_cnt + 1'b1;

      if (w_fall_tick && !w_timeout) begin
        case (r_state)
          IDLE: begin
            r_bit_cnt <= '0;
            r_par_err <= 1'b0;
          end
          DATA: begin
            r_shift   <= {w_data, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          PARITY:  r_par_err <= !odd_parity_ok(r_shift, w_data);
          default: ;
        endcase
      end

      if (w_timeout) begin
        r_ext_flag <= 1'b0;
        r_brk_flag <= 1'b0;
      end else if (w_byte_ok) begin
        if (r_shift == PS2_EXT) begin
          r_ext_flag <= 1'b1;
        end else if (r_shift == PS2_BRK) begin
          r_brk_flag <= 1'b1;
        end else begin
          if (!r_brk_flag) begin
            r_ps2        <= r_shift;
            r_extended   <= r_ext_flag;
            r_code_valid <= 1'b1;
          end else if (r_shift == r_ps2) begin
            r_ps2      <= 8'h00;
            r_extended <= 1'b0;
          end
          r_ext_flag <= 1'b0;
          r_brk_flag <= 1'b0;
        end
      end
    end
  end

  assign o_ps2        = r_ps2;
  assign o_extended   = r_extended;
  assign o_code_valid = r_code_valid;
  assign o_frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: directed scenarios plus random frames against a byte-level
// key-state model; a negedge monitor matches every output pulse to the model's event list.
module tb_ps2_keyboard_rx;
  import ps2_keyboard_rx_pkg::*;

  localparam int FILTER  = 6;
  localparam int TIMEOUT = 300;
  localparam int H       = 20;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] ps2;
  logic       extended;
  logic       code_valid;
  logic       frame_err;

  ps2_keyboard_rx #(
    .FILTER  (FILTER),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .o_ps2        (ps2),
    .o_extended   (extended),
    .o_code_valid (code_valid),
    .o_frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    bit         ext;
  } ev_t;

  ev_t        evq[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_cv     = 0;
  int         n_fe     = 0;
  logic [7:0] m_ps2    = 8'h00;
  bit         m_ext    = 1'b0;
  bit         m_eflag  = 1'b0;
  bit         m_bflag  = 1'b0;
  logic       prev_fall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Key-state model: what a keyboard byte stream means, byte by byte.
  task automatic model_frame(input logic [7:0] b, input bit good);
    ev_t e;
    e.is_err = !good;
    e.code   = b;
    e.ext    = 1'b0;
    if (!good) begin
      evq.push_back(e);
      return;
    end
    if (b == 8'hE0) m_eflag = 1'b1;
    else if (b == 8'hF0) m_bflag = 1'b1;
    else begin
      if (!m_bflag) begin
        m_ps2 = b;
        m_ext = m_eflag;
        e.ext = m_eflag;
        evq.push_back(e);
      end else if (b == m_ps2) begin
        m_ps2 = 8'h00;
        m_ext = 1'b0;
      end
      m_eflag = 1'b0;
      m_bflag = 1'b0;
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clk_bit(input bit d, input bit glitch);
    ps2_data = d;
    if (glitch) begin
      wait_clk(H / 2);
      ps2_clk = 1'b0;
      wait_clk(FILTER - 2);
      ps2_clk = 1'b1;
      wait_clk(H / 2);
    end else begin
      wait_clk(H);
    end
    ps2_clk = 1'b0;
    wait_clk(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int glitch_at);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    model_frame(b, !bad_par && !bad_stop);
    for (int i = 0; i < 11; i++) clk_bit(bits[i], i == glitch_at);
    ps2_data = 1'b1;
    wait_clk(H);
    chk("hold_code", ps2, m_ps2);
    chk("hold_ext", extended, m_ext);
    chk("events_drained", evq.size(), 0);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rst_n && (code_valid || frame_err)) begin
      chk("pulse_overlap", {31'b0, code_valid & frame_err}, 0);
      if (code_valid) n_cv++;
      if (frame_err) n_fe++;
      if (evq.size() == 0) begin
        chk("unexpected_pulse", {30'b0, code_valid, frame_err}, 0);
      end else begin
        e = evq.pop_front();
        if (e.is_err) begin
          chk("frame_err_pulse", {30'b0, code_valid, frame_err}, 1);
        end else begin
          chk("code_valid_pulse", {30'b0, code_valid, frame_err}, 2);
          chk("cv_latency", prev_fall, 1);
          chk("cv_code", ps2, e.code);
          chk("cv_ext", extended, e.ext);
        end
      end
    end
    prev_fall = u_dut.w_fall_tick;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cv0;
    int fe0;
    logic [7:0] codes [5];
    codes = '{8'h6B, 8'h72, 8'h74, 8'h75, 8'h1C};

    wait_clk(3);
    chk("rst_ps2", ps2, 8'h00);
    chk("rst_ext", extended, 0);
    chk("rst_cv", code_valid, 0);
    chk("rst_fe", frame_err, 0);
    rst_n = 1'b1;
    wait_clk(10);

    cv0 = n_cv;
    send_frame(8'h6B, 0, 0, -1);
    chk("6b_code", ps2, 8'h6B);
    chk("6b_ext", extended, 0);
    chk("6b_cv_count", n_cv - cv0, 1);

    cv0 = n_cv;
    send_frame(8'hE0, 0, 0, -1);
    send_frame(8'h75, 0, 0, -1);
    chk("e075_code", ps2, 8'h75);
    chk("e075_ext", extended, 1);
    chk("e075_cv_count", n_cv - cv0, 1);
    cv0 = n_cv;
    send_frame(8'hE0, 0, 0, -1);
    send_frame(8'hF0, 0, 0, -1);
    send_frame(8'h75, 0, 0, -1);
    chk("brk75_code", ps2, 8'h00);
    chk("brk75_ext", extended, 0);
    chk("brk75_cv_count", n_cv - cv0, 0);

    send_frame(8'h72, 0, 0, -1);
    fe0 = n_fe;
    send_frame(8'h74, 1, 0, -1);
    chk("badpar_fe_count", n_fe - fe0, 1);
    chk("badpar_code", ps2, 8'h72);

    cv0 = n_cv;
    send_frame(8'h72, 0, 0, -1);
    chk("typematic_cv_count", n_cv - cv0, 1);

    fe0 = n_fe;
    model_frame(8'h00, 0);
    clk_bit(1'b1, 0);
    wait_clk(H);
    chk("badstart_fe_count", n_fe - fe0, 1);

    fe0 = n_fe;
    model_frame(8'h00, 0);
    m_eflag = 1'b0;
    m_bflag = 1'b0;
    for (int i = 0; i < 5; i++) clk_bit(1'b0, 0);
    ps2_data = 1'b1;
    wait_clk(TIMEOUT + 10);
    chk("timeout_fe_count", n_fe - fe0, 1);
    chk("timeout_fsm_idle", u_dut.r_state, IDLE);
    send_frame(8'h74, 0, 0, -1);
    chk("after_timeout_code", ps2, 8'h74);

    send_frame(8'h1C, 0, 0, 4);
    chk("glitch_code", ps2, 8'h1C);

    send_frame(8'h6B, 0, 0, -1);
    send_frame(8'hF0, 0, 0, -1);
    send_frame(8'h74, 0, 0, -1);
    chk("brk_other_code", ps2, 8'h6B);

    for (int i = 0; i < 4; i++) clk_bit(1'b0, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ps2", ps2, 8'h00);
    chk("midrst_ext", extended, 0);
    evq.delete();
    m_ps2 = 8'h00; m_ext = 1'b0; m_eflag = 1'b0; m_bflag = 1'b0;
    ps2_data = 1'b1;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(10);
    send_frame(8'h75, 0, 0, -1);
    chk("after_rst_code", ps2, 8'h75);

    for (int i = 0; i < 40; i++) begin
      int sel;
      logic [7:0] b;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        2:       b = m_ps2;
        3:       b = 8'($urandom);
        default: b = codes[$urandom_range(0, 4)];
      endcase
      send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0,
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 9)) : -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 Parameter FILTER, default 8, number of consecutive clk cycles ps2_clk must hold a level before the filtered clock follows it.
REQ-002 Parameter TIMEOUT, default 50000, idle clk cycles inside a frame before the frame is aborted (1 ms at 50 MHz).
REQ-003 clk  in  1  system clock; all logic single clock domain.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 ps2_clk  in  1  raw keyboard clock, asynchronous, idles high.
REQ-006 ps2_data  in  1  raw keyboard data, asynchronous, idles high.
REQ-007 ps2  out  8  scan code of the key currently held; 8'h00 when no key is held; drives the direction decoder directly.
REQ-008 extended  out  1  1 when the held code was preceded by an 8'hE0 prefix.
REQ-009 code_valid  out  1  one-cycle pulse when ps2 is written by a make code.
REQ-010 frame_err  out  1  one-cycle pulse on a start, parity, stop or timeout error.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-012 The filtered clock SHALL change level only after the synchronized ps2_clk differs from it for FILTER consecutive cycles; shorter glitches are ignored.
REQ-013 fall_tick SHALL be a one-cycle pulse on each 1->0 transition of the filtered clock; synchronized ps2_data is sampled only on fall_tick.
REQ-014 Receive FSM states: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: on fall_tick, a data value of 0 moves the FSM to DATA; a value of 1 raises frame_err and keeps it in IDLE.
REQ-016 DATA: SHALL shift 8 bits LSB first with a 3-bit counter, then move to PARITY.
REQ-017 PARITY: the sampled bit SHALL make the 9 bits odd parity; a mismatch is latched as an error and the FSM moves to STOP.
REQ-018 STOP: on fall_tick, return to IDLE; the byte is accepted only if stop=1 and parity is correct, otherwise frame_err pulses and the byte is discarded.
REQ-019 Outputs for an accepted byte SHALL update in the cycle immediately after the stop-bit fall_tick (latency 1 clk).
REQ-020 Byte 8'hE0 SHALL set ext_flag; byte 8'hF0 SHALL set brk_flag; neither changes ps2 or pulses code_valid.
REQ-021 Any other byte with brk_flag=0 SHALL give ps2<=byte, extended<=ext_flag, code_valid pulse; then both flags clear.
REQ-022 Any other byte with brk_flag=1 SHALL clear ps2 and extended only when byte equals ps2 (otherwise leave them unchanged), with no code_valid pulse; then both flags clear.
REQ-023 Typematic repeat of the held make code SHALL rewrite the same value and pulse code_valid again.
REQ-024 An idle counter SHALL clear on every fall_tick and count while the FSM is not in IDLE; on reaching TIMEOUT the FSM returns to IDLE, frame_err pulses, and ext_flag and brk_flag clear.
REQ-025 Any error SHALL leave ps2 and extended unchanged.
REQ-026 code_valid and frame_err SHALL never assert in the same cycle.

Reset
REQ-027 rst_n low SHALL immediately force FSM=IDLE, ps2=8'h00, extended=0, code_valid=0, frame_err=0, flags=0, counters=0, and filtered clock=1.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; the first complete frame after release SHALL decode normally.

Structure
REQ-029 The shared package SHALL hold the FSM state encoding, the constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0, and the FILTER and TIMEOUT defaults.
REQ-030 The synchronizer, glitch filter and fall_tick generator SHALL form one sub-module, ps2_clk_filter; the FSM and decode live in the top module.

Verification
REQ-031 Frame 8'h6B, parity 0, stop 1 -> code_valid pulses once, ps2=8'h6B, extended=0, one cycle after the stop-bit fall_tick.
REQ-032 E0, 75, then E0, F0, 75 -> after the first pair ps2=8'h75, extended=1, one code_valid; after the break ps2=8'h00, extended=0, no code_valid.
REQ-033 Hold 8'h72, then send frame 8'h74 with wrong parity -> frame_err pulses once, ps2 stays 8'h72.
REQ-034 Send start bit plus 4 data bits, then silence for TIMEOUT+10 cycles -> frame_err pulses once, FSM in IDLE; a following 8'h74 frame gives ps2=8'h74.
REQ-035 A ps2_clk low glitch of FILTER-2 cycles mid-frame -> no extra bit shifted; the frame still decodes correctly.
REQ-036 Hold 8'h6B, then F0, 74 -> ps2 stays 8'h6B; rst_n low mid-frame -> ps2=8'h00 immediately, and the next 8'h75 frame decodes.
